// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array result path.
package systolic_pkg;

    localparam int unsigned NUM_ELEMS = 4;
    localparam int unsigned IDX_W     = 2;

    localparam logic [IDX_W-1:0] IDX_C00 = 2'd0;
    localparam logic [IDX_W-1:0] IDX_C01 = 2'd1;
    localparam logic [IDX_W-1:0] IDX_C10 = 2'd2;
    localparam logic [IDX_W-1:0] IDX_C11 = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

endpackage

// File: rtl/tile_bank.sv
// Two-entry tile store: four result words plus a tile tag per entry, FIFO-ordered.
module tile_bank
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wr_en,
    input  logic [NUM_ELEMS-1:0][WIDTH-1:0]    wr_data,
    input  logic [TAG_W-1:0]                   wr_tag,
    input  logic                               pop,
    input  logic [IDX_W-1:0]                   rd_elem,
    output logic [WIDTH-1:0]                   rd_data,
    output logic [TAG_W-1:0]                   rd_tag,
    output logic [1:0]                         count
);

    logic [NUM_ELEMS-1:0][WIDTH-1:0] data_q [2];
    logic [TAG_W-1:0]                tag_q  [2];
    logic                            wr_ptr;
    logic                            rd_ptr;

    // Pointers and occupancy; a write into a full bank is only issued alongside a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) wr_ptr <= ~wr_ptr;
            if (pop)   rd_ptr <= ~rd_ptr;
            count <= count + 2'(wr_en) - 2'(pop);
        end
    end

    // Payload storage needs no reset: contents are ignored while count is zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_ptr] <= wr_data;
            tag_q[wr_ptr]  <= wr_tag;
        end
    end

    assign rd_data = data_q[rd_ptr][rd_elem];
    assign rd_tag  = tag_q[rd_ptr];

endmodule

// File: rtl/systolic_result_drain.sv
// Captures 2x2 systolic results on each rising done and streams them out as tagged beats.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned TAG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic [WIDTH-1:0]  result0,
    input  logic [WIDTH-1:0]  result1,
    input  logic [WIDTH-1:0]  result2,
    input  logic [WIDTH-1:0]  result3,
    input  logic              clr_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic [1:0]        m_idx,
    output logic              m_last,
    output logic [TAG_W-1:0]  m_tile,
    output logic              array_release,
    output logic              busy,
    output logic              ovf_err
);

    logic                            done_d;
    logic                            cap_evt;
    logic                            cap_ok;
    logic                            hs;
    logic                            pop;
    logic [1:0]                      count;
    logic [1:0]                      count_nxt;
    logic [IDX_W-1:0]                elem;
    logic [TAG_W-1:0]                tile_cnt;
    logic [TAG_W-1:0]                rd_tag;
    logic [WIDTH-1:0]                rd_data;
    logic [NUM_ELEMS-1:0][WIDTH-1:0] results;
    drain_state_t                    state;
    drain_state_t                    state_nxt;

    assign results = {result3, result2, result1, result0};

    // A full bank still accepts a capture when the oldest tile frees its slot this cycle.
    assign cap_evt   = done_in & ~done_d;
    assign hs        = m_valid & m_ready;
    assign pop       = hs & (elem == IDX_C11);
    assign cap_ok    = cap_evt & ((count != 2'd2) | pop);
    assign count_nxt = count + 2'(cap_ok) - 2'(pop);
    assign busy      = (count != 2'd0);

    tile_bank #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cap_ok),
        .wr_data (results),
        .wr_tag  (tile_cnt),
        .pop     (pop),
        .rd_elem (elem),
        .rd_data (rd_data),
        .rd_tag  (rd_tag),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count_nxt != 2'd0) state_nxt = STREAM;
            STREAM:  if (count_nxt == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beat fields are forced to zero outside STREAM so stale bank contents never leak out.
    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_idx   = IDX_C00;
        m_last  = 1'b0;
        m_tile  = '0;
        if (state == STREAM) begin
            m_valid = 1'b1;
            m_data  = rd_data;
            m_idx   = elem;
            m_last  = (elem == IDX_C11);
            m_tile  = rd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_d        <= 1'b1;
            tile_cnt      <= '0;
            elem          <= IDX_C00;
            array_release <= 1'b0;
            ovf_err       <= 1'b0;
        end else begin
            done_d        <= done_in;
            array_release <= cap_ok;
            if (cap_ok) tile_cnt <= tile_cnt + TAG_W'(1);
            if (hs)     elem     <= elem + IDX_W'(1);
            if (cap_evt & ~cap_ok) ovf_err <= 1'b1;
            else if (clr_err)      ovf_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: cycle table for single/backpressured/double tiles, then hand sequences.
module tb_systolic_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_in;
    logic [15:0] result0, result1, result2, result3;
    logic        clr_err;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [1:0]  m_idx;
    logic        m_last;
    logic [7:0]  m_tile;
    logic        array_release;
    logic        busy;
    logic        ovf_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_result_drain #(.WIDTH(16), .TAG_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .done_in       (done_in),
        .result0       (result0),
        .result1       (result1),
        .result2       (result2),
        .result3       (result3),
        .clr_err       (clr_err),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_idx         (m_idx),
        .m_last        (m_last),
        .m_tile        (m_tile),
        .array_release (array_release),
        .busy          (busy),
        .ovf_err       (ovf_err)
    );

    // One row: inputs applied before an edge, outputs expected just after it.
    typedef struct {
        logic        done;
        logic        rdy;
        logic [15:0] r0, r1, r2, r3;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  ei;
        logic        el;
        logic [7:0]  et;
        logic        erel;
        logic        eb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic done, input logic rdy, input int r0, input int r1,
                                input int r2, input int r3, input logic ev, input int ed, input int ei,
                                input logic el, input int et, input logic erel, input logic eb);
        vec_t v;
        v.done = done; v.rdy = rdy;
        v.r0 = 16'(r0); v.r1 = 16'(r1); v.r2 = 16'(r2); v.r3 = 16'(r3);
        v.ev = ev; v.ed = 16'(ed); v.ei = 2'(ei); v.el = el; v.et = 8'(et);
        v.erel = erel; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input int a, input int b, input int c, input int d);
        result0 = 16'(a); result1 = 16'(b); result2 = 16'(c); result3 = 16'(d);
    endtask

    task automatic exp_beat(input string name, input int d, input int i, input logic l, input int t);
        chk({name, ".valid"}, 32'(m_valid), 32'd1);
        chk({name, ".data"},  32'(m_data),  32'(d));
        chk({name, ".idx"},   32'(m_idx),   32'(i));
        chk({name, ".last"},  32'(m_last),  32'(l));
        chk({name, ".tile"},  32'(m_tile),  32'(t));
    endtask

    // Drain one full tile with m_ready high, data base+0..base+3.
    task automatic drain_tile(input string name, input int base, input int t);
        for (int k = 0; k < 4; k++) begin
            exp_beat($sformatf("%s.b%0d", name, k), base + k, k, k == 3, t);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; done_in = 1'b0; clr_err = 1'b0; m_ready = 1'b1;
        set_res(0, 0, 0, 0);
        step(); step();
        chk("rst.valid",   32'(m_valid),       32'd0);
        chk("rst.release", 32'(array_release), 32'd0);
        chk("rst.busy",    32'(busy),          32'd0);
        chk("rst.ovf",     32'(ovf_err),       32'd0);
        chk("rst.data",    32'(m_data),        32'd0);
        rst = 1'b0;

        // Basic tile, tile 0
        vt.push_back(mk(0,1, 0,0,0,0, 0,0,0,0,0, 0,0));
        vt.push_back(mk(1,1, 3,5,7,9, 1,3,0,0,0, 1,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,5,1,0,0, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,7,2,0,0, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,9,3,1,0, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 0,0,0,0,0, 0,0));
        // Backpressure on idx 1, tile 1
        vt.push_back(mk(1,1, 3,5,7,9, 1,3,0,0,1, 1,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,5,1,0,1, 0,1));
        vt.push_back(mk(0,0, 0,0,0,0, 1,5,1,0,1, 0,1));
        vt.push_back(mk(0,0, 0,0,0,0, 1,5,1,0,1, 0,1));
        vt.push_back(mk(0,0, 0,0,0,0, 1,5,1,0,1, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,7,2,0,1, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,9,3,1,1, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 0,0,0,0,0, 0,0));
        // Double buffering: tiles 2 and 3 two cycles apart, no bubble
        vt.push_back(mk(1,1, 1,2,3,4, 1,1,0,0,2, 1,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,2,1,0,2, 0,1));
        vt.push_back(mk(1,1, 5,6,7,8, 1,3,2,0,2, 1,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,4,3,1,2, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,5,0,0,3, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,6,1,0,3, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,7,2,0,3, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 1,8,3,1,3, 0,1));
        vt.push_back(mk(0,1, 0,0,0,0, 0,0,0,0,0, 0,0));

        for (int i = 0; i < vt.size(); i++) begin
            done_in = vt[i].done; m_ready = vt[i].rdy;
            set_res(int'(vt[i].r0), int'(vt[i].r1), int'(vt[i].r2), int'(vt[i].r3));
            step();
            chk($sformatf("row%0d.valid", i),   32'(m_valid),       32'(vt[i].ev));
            chk($sformatf("row%0d.data", i),    32'(m_data),        32'(vt[i].ed));
            chk($sformatf("row%0d.idx", i),     32'(m_idx),         32'(vt[i].ei));
            chk($sformatf("row%0d.last", i),    32'(m_last),        32'(vt[i].el));
            chk($sformatf("row%0d.tile", i),    32'(m_tile),        32'(vt[i].et));
            chk($sformatf("row%0d.release", i), 32'(array_release), 32'(vt[i].erel));
            chk($sformatf("row%0d.busy", i),    32'(busy),          32'(vt[i].eb));
            chk($sformatf("row%0d.ovf", i),     32'(ovf_err),       32'd0);
        end

        // Overflow: three captures with the sink stalled; third (would-be tile 6) is dropped
        m_ready = 1'b0;
        done_in = 1'b1; set_res(10, 11, 12, 13); step();
        chk("ovf.rel1", 32'(array_release), 32'd1);
        done_in = 1'b0; step();
        done_in = 1'b1; set_res(20, 21, 22, 23); step();
        chk("ovf.rel2", 32'(array_release), 32'd1);
        chk("ovf.err_pre", 32'(ovf_err), 32'd0);
        done_in = 1'b0; step();
        done_in = 1'b1; set_res(30, 31, 32, 33); step();
        chk("ovf.rel3", 32'(array_release), 32'd0);
        chk("ovf.err",  32'(ovf_err),       32'd1);
        chk("ovf.busy", 32'(busy),          32'd1);
        done_in = 1'b0; step();
        exp_beat("ovf.hold", 10, 0, 1'b0, 4);
        m_ready = 1'b1;
        drain_tile("ovf.t4", 10, 4);
        drain_tile("ovf.t5", 20, 5);
        chk("ovf.empty", 32'(m_valid), 32'd0);
        chk("ovf.err_kept", 32'(ovf_err), 32'd1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("ovf.cleared", 32'(ovf_err), 32'd0);

        // Full bank with a capture on the final-beat handshake
        m_ready = 1'b0;
        done_in = 1'b1; set_res(40, 41, 42, 43); step();
        done_in = 1'b0; step();
        done_in = 1'b1; set_res(50, 51, 52, 53); step();
        done_in = 1'b0; step();
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_beat($sformatf("sim.p%0d", k), 40 + k, k, 1'b0, 6);
            step();
        end
        exp_beat("sim.p3", 43, 3, 1'b1, 6);
        done_in = 1'b1; set_res(60, 61, 62, 63); step();
        done_in = 1'b0;
        chk("sim.release", 32'(array_release), 32'd1);
        chk("sim.ovf",     32'(ovf_err),       32'd0);
        drain_tile("sim.q", 50, 7);
        chk("sim.busy_r", 32'(busy), 32'd1);
        drain_tile("sim.r", 60, 8);
        chk("sim.empty", 32'(m_valid), 32'd0);
        chk("sim.idle",  32'(busy),    32'd0);

        // done held high across reset release must not capture
        done_in = 1'b1; set_res(99, 99, 99, 99);
        rst = 1'b1; step(); step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("held.valid%0d", k), 32'(m_valid),       32'd0);
            chk($sformatf("held.rel%0d", k),   32'(array_release), 32'd0);
        end
        done_in = 1'b0; step();
        done_in = 1'b1; set_res(70, 71, 72, 73); step();
        done_in = 1'b0;
        exp_beat("held.b0", 70, 0, 1'b0, 0);
        chk("held.release", 32'(array_release), 32'd1);
        step();
        exp_beat("held.b1", 71, 1, 1'b0, 0);
        step();
        exp_beat("held.b2", 72, 2, 1'b0, 0);

        // Reset mid-tile abandons the tile and restarts numbering
        rst = 1'b1; step();
        chk("mid.valid", 32'(m_valid), 32'd0);
        chk("mid.busy",  32'(busy),    32'd0);
        rst = 1'b0; step();
        done_in = 1'b1; set_res(80, 81, 82, 83); step();
        done_in = 1'b0;
        chk("mid.release", 32'(array_release), 32'd1);
        drain_tile("mid.t0", 80, 0);
        chk("mid.empty", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
